wport_rx_player: RTL and testbench
==================================

# wport_rx_player

Receive-side consumer of a tProcessor wave output port. It accepts 168-bit wave words over AXI-Stream with backpressure and buffers them in a small FIFO. It then plays them out one at a time, holding each word's parameters for the number of clock cycles given in its length field. It sits at the signal-generator end of the `m*_axis` wave ports and is the sink that drives `m*_axis_tready`.

## Interface
Parameters:
- `FIFO_AW`, 3, FIFO address width; depth = 2**FIFO_AW words.
- `DW`, 168, wave word width; fixed layout below, must be 168.

Ports:
- `t_clk_i`  in  1  single clock for the whole block.
- `t_rst_i`  in  1  reset; synchronous, active-high.
- `s_axis_tdata`  in  168  wave word: [15:0] length in cycles, [167:16] parameters.
- `s_axis_tvalid`  in  1  word valid.
- `s_axis_tready`  out  1  block can accept a word.
- `en_i`  in  1  playback enable; low freezes playback.
- `wave_dt_o`  out  152  parameters of the word currently playing.
- `wave_vld_o`  out  1  high while a word is playing.
- `wave_new_o`  out  1  one-cycle pulse in the first cycle of each word.
- `starve_o`  out  1  one-cycle pulse when a word ends and the FIFO is empty.
- `fifo_cnt_o`  out  FIFO_AW+1  words stored, 0..2**FIFO_AW.

## Operation
- FIFO:
  - Push on `s_axis_tvalid & s_axis_tready`.
  - `s_axis_tready = !t_rst_i & (fifo_cnt != 2**FIFO_AW)`. There is no pass-through when full.
  - Read and write pointers wrap modulo depth.
  - Simultaneous push and pop leave the count unchanged.
- Length rule: a length field of 0 is treated as 1. The remaining-cycle counter (16 bit) loads `max(len,1)-1`.
- FSM states: IDLE and PLAY.
  - IDLE:
    - If `en_i` is high and the FIFO is non-empty: pop, load `wave_dt_o` and the counter, pulse `wave_new_o`, go to PLAY.
    - Otherwise stay in IDLE with `wave_vld_o = 0`.
  - PLAY, with `en_i = 0`: hold the counter, `wave_dt_o` and `wave_vld_o` unchanged.
  - PLAY, with `en_i = 1` and counter != 0: decrement the counter.
  - PLAY, with `en_i = 1` and counter == 0:
    - FIFO non-empty: pop the next word back-to-back (no gap cycle), pulse `wave_new_o`, stay in PLAY.
    - FIFO empty: go to IDLE, drop `wave_vld_o`, pulse `starve_o`.
- `wave_dt_o` keeps the last played parameters while in IDLE.
- Reset:
  - Clears the FIFO (contents discarded), pointers and counter; FSM goes to IDLE.
  - All outputs are 0 while `t_rst_i` is high, including `s_axis_tready`.
  - Reset asserted mid-word aborts that word; no `starve_o` pulse.

## Timing
- All outputs are registered, except `s_axis_tready`, which is a combinational decode of the registered count and `t_rst_i`.
- Latency: handshake in cycle T into an empty FIFO with IDLE and `en_i` high gives `wave_new_o`/`wave_vld_o` first high in cycle T+2.
- A word of length L with `en_i` held high keeps `wave_vld_o` high for exactly L cycles (1 cycle if L=0).
- `fifo_cnt_o` updates in the cycle after the push or pop.
- When full, a pop in cycle P raises `s_axis_tready` in cycle P+1.
- `starve_o` is high in the cycle after the last cycle of the final word, coinciding with `wave_vld_o` falling.
- `en_i` is sampled each cycle. An `en_i` low cycle extends the current word by one cycle.
- In IDLE with `en_i` low, no pop occurs and the FIFO holds its contents.

## Test plan
- Reset: hold `t_rst_i` 3 cycles while driving `s_axis_tvalid` = 1.
  - During reset: `s_axis_tready` = 0, all outputs 0, nothing stored.
  - After reset: `s_axis_tready` = 1, `fifo_cnt_o` = 0.
- Single word: length 3, parameters 0xABC, handshake in cycle T, `en_i` = 1.
  - `wave_new_o` pulses in cycle T+2.
  - `wave_vld_o` is high in cycles T+2..T+4 with `wave_dt_o` = 0xABC.
  - `starve_o` pulses in cycle T+5 and `wave_vld_o` is low from T+5.
- Back-to-back: preload lengths 2, 1, 0 (parameters 1, 2, 3), then set `en_i` = 1.
  - `wave_vld_o` stays continuously high for 4 cycles.
  - `wave_new_o` pulses at offsets 0, 2, 3, with `wave_dt_o` = 1, 2, 3 respectively.
  - A single `starve_o` pulse follows.
- Full/backpressure: with `en_i` = 0, stream 9 words with `s_axis_tvalid` held high (default `FIFO_AW`).
  - 8 words are accepted, `fifo_cnt_o` = 8, and `s_axis_tready` falls.
  - Raise `en_i`: one pop, `s_axis_tready` rises the next cycle, the 9th word is accepted, and `fifo_cnt_o` stays at 8.
- Stall: length 4 word; drop `en_i` for 3 cycles after its first cycle.
  - `wave_vld_o` is high for 7 cycles and `wave_dt_o` is stable throughout.
  - Only one `wave_new_o` pulse occurs.
- Reset mid-play: assert `t_rst_i` in the 2nd cycle of a length 10 word with 3 words queued.
  - Next cycle: `wave_vld_o` = 0, `fifo_cnt_o` = 0, no `starve_o`.
  - After release, no stale word plays.

Source files
------------

// File: rtl/wport_rx_player.sv
// Receive-side wave port player: buffers 168-bit wave words from an
// AXI-Stream sink port and plays them out one at a time. Each word holds its
// parameters on wave_dt_o for the number of cycles in its length field.
module wport_rx_player #(
  parameter int FIFO_AW = 3,
  parameter int DW      = 168
) (
  input  logic              t_clk_i,
  input  logic              t_rst_i,
  input  logic [DW-1:0]     s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              en_i,
  output logic [DW-17:0]    wave_dt_o,
  output logic              wave_vld_o,
  output logic              wave_new_o,
  output logic              starve_o,
  output logic [FIFO_AW:0]  fifo_cnt_o
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int PW    = DW - 16;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic {IDLE, PLAY} state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     cnt_q, cnt_d;
  logic [15:0]          rem_q, rem_d;
  logic [PW-1:0]        dt_q, dt_d;
  logic                 vld_q, vld_d;
  logic                 new_q, new_d;
  logic                 starve_q, starve_d;
  logic                 push, pop, empty;
  logic [DW-1:0]        head;

  // A zero length still plays for one cycle; counter holds cycles left after this one.
  function automatic logic [15:0] len_to_rem(input logic [15:0] len);
    return (len == 16'd0) ? 16'd0 : len - 16'd1;
  endfunction

  // No pass-through when full: ready is purely a decode of the stored count.
  assign s_axis_tready = !t_rst_i && (cnt_q != FULL_CNT);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign empty         = (cnt_q == '0);
  assign head          = mem_q[rd_ptr_q];

  assign wave_dt_o  = dt_q;
  assign wave_vld_o = vld_q;
  assign wave_new_o = new_q;
  assign starve_o   = starve_q;
  assign fifo_cnt_o = cnt_q;

  // Playback FSM next state: decides when to pop and what the outputs become.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dt_d     = dt_q;
    vld_d    = vld_q;
    new_d    = 1'b0;
    starve_d = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (en_i && !empty) pop = 1'b1;
      end
      PLAY: begin
        if (en_i) begin
          if (rem_q != 16'd0) begin
            rem_d = rem_q - 16'd1;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d  = IDLE;
            vld_d    = 1'b0;
            starve_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Loading a word is identical whether it starts from IDLE or back-to-back.
    if (pop) begin
      state_d = PLAY;
      rem_d   = len_to_rem(head[15:0]);
      dt_d    = head[DW-1:16];
      vld_d   = 1'b1;
      new_d   = 1'b1;
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control and output registers; reset drops any word in flight without a starve pulse.
  always_ff @(posedge t_clk_i) begin
    if (t_rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      dt_q     <= '0;
      vld_q    <= 1'b0;
      new_q    <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dt_q     <= dt_d;
      vld_q    <= vld_d;
      new_q    <= new_d;
      starve_q <= starve_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge t_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

endmodule

// File: tb/tb_wport_rx_player.sv
// Self-checking bench for wport_rx_player: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based player model.
module tb_wport_rx_player;

  localparam int FIFO_AW = 3;
  localparam int DEPTH   = 2 ** FIFO_AW;

  logic           clk = 1'b0;
  logic           rst;
  logic [167:0]   tdata;
  logic           tvalid;
  logic           tready;
  logic           en;
  logic [151:0]   dt;
  logic           vld, newp, starve;
  logic [FIFO_AW:0] cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [167:0] q[$];
  bit           m_play;
  int           m_left;
  logic [151:0] m_dt;
  bit           m_new, m_starve;

  always #5 clk = ~clk;

  wport_rx_player #(.FIFO_AW(FIFO_AW), .DW(168)) dut (
    .t_clk_i(clk), .t_rst_i(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .en_i(en),
    .wave_dt_o(dt), .wave_vld_o(vld), .wave_new_o(newp), .starve_o(starve),
    .fifo_cnt_o(cnt)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [167:0] mk(input logic [15:0] len, input logic [151:0] p);
    return {p, len};
  endfunction

  function automatic logic [151:0] rnd_p();
    return 152'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  // Model one clock edge: finish/advance the playing word, start the next, then accept input.
  task automatic model_step();
    bit acc, start;
    logic [167:0] w;
    if (rst) begin
      q.delete();
      m_play = 0; m_left = 0; m_dt = '0; m_new = 0; m_starve = 0;
    end else begin
      acc = tvalid && (q.size() < DEPTH);
      m_new = 0; m_starve = 0; start = 0;
      if (m_play) begin
        if (en) begin
          m_left--;
          if (m_left == 0) begin
            if (q.size() > 0) start = 1;
            else begin m_play = 0; m_starve = 1; end
          end
        end
      end else if (en && q.size() > 0) begin
        start = 1;
      end
      if (start) begin
        w = q.pop_front();
        m_left = (w[15:0] == 16'd0) ? 1 : int'(w[15:0]);
        m_dt = w[167:16];
        m_new = 1; m_play = 1;
      end
      if (acc) q.push_back(tdata);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    chk("tready", tready, (!rst && q.size() < DEPTH));
    chk("cnt", cnt, q.size());
    chk("vld", vld, m_play);
    chk("new", newp, m_new);
    chk("starve", starve, m_starve);
    chk("dt", dt, m_dt);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic drain();
    tvalid = 0; en = 1;
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !m_play) break;
      cyc();
    end
    sample();
    chk("drain_vld", vld, 0);
    chk("drain_cnt", cnt, 0);
    advance();
  endtask

  initial begin : stim
    bit va[8], na[8], sa[8];
    logic [151:0] da[8];
    int f, run, nst, nvld, nnew, dbad;
    bit found;

    // Reset held 3 cycles with tvalid high
    rst = 1; en = 0; tvalid = 1; tdata = mk(16'd5, rnd_p());
    advance();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_tready", tready, 0);
      chk("rst_vld", vld, 0);
      chk("rst_cnt", cnt, 0);
      advance();
    end
    rst = 0; tvalid = 0;
    sample();
    chk("post_rst_tready", tready, 1);
    chk("post_rst_cnt", cnt, 0);
    advance();

    // Single word, length 3, parameters 0xABC
    en = 1; tdata = mk(16'd3, 152'hABC); tvalid = 1;
    cyc();
    tvalid = 0;
    for (int k = 1; k <= 5; k++) begin
      sample();
      case (k)
        1: chk("single_t1_vld", vld, 0);
        2: begin
          chk("single_t2_new", newp, 1);
          chk("single_t2_vld", vld, 1);
          chk("single_t2_dt", dt, 152'hABC);
        end
        3, 4: begin
          chk("single_vld", vld, 1);
          chk("single_new", newp, 0);
          chk("single_dt", dt, 152'hABC);
        end
        default: begin
          chk("single_t5_starve", starve, 1);
          chk("single_t5_vld", vld, 0);
        end
      endcase
      advance();
    end
    cyc();

    // Back-to-back: lengths 2,1,0 with parameters 1,2,3
    en = 0; tvalid = 1;
    tdata = mk(16'd2, 152'd1); cyc();
    tdata = mk(16'd1, 152'd2); cyc();
    tdata = mk(16'd0, 152'd3); cyc();
    tvalid = 0; cyc();
    en = 1;
    for (int i = 0; i < 8; i++) begin
      sample();
      va[i] = vld; na[i] = newp; sa[i] = starve; da[i] = dt;
      advance();
    end
    f = -1;
    for (int i = 7; i >= 0; i--) if (va[i]) f = i;
    chk("b2b_first", f, 1);
    if (f >= 0 && f <= 3) begin
      run = 0;
      for (int i = f; i < 8 && va[i]; i++) run++;
      chk("b2b_run", run, 4);
      chk("b2b_new0", na[f], 1);
      chk("b2b_dt0", da[f], 152'd1);
      chk("b2b_gap", na[f+1], 0);
      chk("b2b_new2", na[f+2], 1);
      chk("b2b_dt2", da[f+2], 152'd2);
      chk("b2b_new3", na[f+3], 1);
      chk("b2b_dt3", da[f+3], 152'd3);
      chk("b2b_starve", sa[f+4], 1);
    end
    nst = 0;
    for (int i = 0; i < 8; i++) nst += int'(sa[i]);
    chk("b2b_starve_cnt", nst, 1);

    // Full / backpressure
    en = 0; tvalid = 1;
    for (int i = 0; i < 8; i++) begin
      tdata = mk(16'($urandom_range(0, 3)), rnd_p());
      cyc();
    end
    tdata = mk(16'd1, 152'h999);
    sample();
    chk("full_cnt", cnt, 8);
    chk("full_tready", tready, 0);
    advance();
    cyc();
    en = 1;
    sample(); advance();
    en = 0;
    sample();
    chk("pop_tready", tready, 1);
    chk("pop_cnt", cnt, 7);
    advance();
    tvalid = 0;
    sample();
    chk("refill_cnt", cnt, 8);
    chk("refill_tready", tready, 0);
    advance();
    drain();

    // Stall: length 4, en low for 3 cycles after the first cycle
    en = 1; tdata = mk(16'd4, 152'h5A5); tvalid = 1;
    cyc();
    tvalid = 0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (newp) begin found = 1; break; end
      advance();
    end
    chk("stall_found", found, 1);
    nvld = int'(vld); nnew = int'(newp); dbad = 0;
    advance();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      nvld += int'(vld); nnew += int'(newp);
      if (dt !== 152'h5A5) dbad++;
      advance();
    end
    en = 1;
    for (int i = 0; i < 6; i++) begin
      sample();
      nvld += int'(vld); nnew += int'(newp);
      if (vld && dt !== 152'h5A5) dbad++;
      advance();
    end
    chk("stall_vld_cycles", nvld, 7);
    chk("stall_new_cnt", nnew, 1);
    chk("stall_dt_stable", dbad, 0);

    // Reset in the 2nd cycle of a length-10 word with 3 words queued
    en = 0; tvalid = 1;
    tdata = mk(16'd10, 152'h10); cyc();
    for (int i = 0; i < 3; i++) begin
      tdata = mk(16'd2, rnd_p()); cyc();
    end
    tvalid = 0; en = 1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (newp) begin found = 1; break; end
      advance();
    end
    chk("midrst_found", found, 1);
    advance();
    sample();
    rst = 1;
    advance();
    rst = 0;
    sample();
    chk("midrst_vld", vld, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_starve", starve, 0);
    advance();
    nvld = 0;
    for (int i = 0; i < 15; i++) begin
      sample();
      nvld += int'(vld) + int'(newp);
      advance();
    end
    chk("midrst_no_stale", nvld, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      tvalid = ($urandom % 3) != 0;
      tdata  = mk(16'($urandom_range(0, 4)), rnd_p());
      en     = ($urandom % 4) != 0;
      rst    = ($urandom % 200) == 0;
      cyc();
    end
    rst = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
